// File: rtl/anim_offset_ctrl_pkg.sv
// Shared constants for the animation controller and the scene/player renderers.
package anim_offset_ctrl_pkg;

    localparam int WRAP        = 400;  // scroll period in pixels
    localparam int BAR_WIDTH   = 40;   // sine-bar width in pixels
    localparam int NUM_BARS    = 10;   // sine LUT entries
    localparam int PLAYER_BAR  = 5;    // PLAYER_X / BAR_WIDTH
    localparam int RESET_SPEED = 4;

    localparam int OFF_W = 10;
    localparam int BAR_W = 4;
    localparam int SPD_W = 4;

    typedef enum logic {
        IDLE,
        DIV
    } div_state_t;

endpackage

// File: rtl/offset_bar_divider.sv
// Repeated-subtraction divider: player_bar = (x_offset / BAR_WIDTH + PLAYER_BAR) mod NUM_BARS.
module offset_bar_divider
    import anim_offset_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OFF_W-1:0] x_offset,
    output logic [BAR_W-1:0] player_bar,
    output logic             player_bar_valid
);

    div_state_t       state_q, state_d;
    logic [OFF_W-1:0] rem_q, rem_d;
    logic [BAR_W-1:0] q_q, q_d;
    logic [BAR_W-1:0] bar_d;
    logic             valid_d;
    logic [BAR_W:0]   bar_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            rem_q            <= '0;
            q_q              <= '0;
            player_bar       <= BAR_W'(PLAYER_BAR % NUM_BARS);
            player_bar_valid <= 1'b1;
        end else begin
            // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
            state_q          <= state_d;
            rem_q            <= rem_d;
            q_q              <= q_d;
            player_bar       <= bar_d;
            player_bar_valid <= valid_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_d = state_q;
        rem_d   = rem_q;
        q_d     = q_q;
        bar_d   = player_bar;
        valid_d = player_bar_valid;
        bar_sum = {1'b0, q_q} + (BAR_W+1)'(PLAYER_BAR);

        // A new offset always wins, even mid-division.
        if (start) begin
            state_d = DIV;
            rem_d   = x_offset;
            q_d     = '0;
            valid_d = 1'b0;
        end else if (state_q == DIV) begin
            if (rem_q >= OFF_W'(BAR_WIDTH)) begin
                rem_d = rem_q - OFF_W'(BAR_WIDTH);
                q_d   = q_q + 1'b1;
            end else begin
                bar_d   = (bar_sum >= (BAR_W+1)'(NUM_BARS))
                        ? BAR_W'(bar_sum - (BAR_W+1)'(NUM_BARS))
                        : bar_sum[BAR_W-1:0];
                valid_d = 1'b1;
                state_d = IDLE;
            end
        end
    end

endmodule

// File: rtl/anim_offset_ctrl.sv
// Frame-rate scroll controller: vsync edge detect, switch sampling, modulo-WRAP offset update.
module anim_offset_ctrl
    import anim_offset_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync,
    input  logic [SPD_W-1:0] speed_sw,
    input  logic             dir_sw,
    output logic             frame_tick,
    output logic             started,
    output logic [OFF_W-1:0] x_offset,
    output logic [BAR_W-1:0] player_bar,
    output logic             player_bar_valid
);

    logic [SPD_W-1:0] speed_meta, speed_s, speed_reg;
    logic             dir_meta, dir_s, dir_reg;
    logic             vsync_d;
    logic             div_start;

    logic [SPD_W-1:0] spd;
    logic [OFF_W-1:0] delta;
    logic [OFF_W:0]   sum;
    logic [OFF_W-1:0] next_off;

    // NOTE: the switches are asynchronous to clk, so each goes through two flops before use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            speed_meta <= '0;
            speed_s    <= '0;
            dir_meta   <= 1'b0;
            dir_s      <= 1'b0;
        end else begin
            speed_meta <= speed_sw;
            speed_s    <= speed_meta;
            dir_meta   <= dir_sw;
            dir_s      <= dir_meta;
        end
    end

    always_comb begin
        spd      = (speed_reg == '0) ? SPD_W'(1) : speed_reg;
        delta    = dir_reg ? (OFF_W'(WRAP) - OFF_W'(spd)) : OFF_W'(spd);
        sum      = {1'b0, x_offset} + {1'b0, delta};
        // Both operands are below WRAP, so one subtraction restores the range.
        next_off = (sum >= (OFF_W+1)'(WRAP)) ? OFF_W'(sum - (OFF_W+1)'(WRAP)) : sum[OFF_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_d    <= 1'b0;
            frame_tick <= 1'b0;
            started    <= 1'b0;
            x_offset   <= '0;
            speed_reg  <= SPD_W'(RESET_SPEED);
            dir_reg    <= 1'b0;
            div_start  <= 1'b0;
        end else begin
            vsync_d    <= vsync;
            frame_tick <= vsync & ~vsync_d;
            div_start  <= frame_tick & started;
            if (frame_tick) begin
                // The first tick only arms the controller; the offset starts moving on the next one.
                if (!started) begin
                    started <= 1'b1;
                end else begin
                    x_offset <= next_off;
                end
                speed_reg <= speed_s;
                dir_reg   <= dir_s;
            end
        end
    end

    offset_bar_divider u_divider (
        .clk              (clk),
        .reset            (reset),
        .start            (div_start),
        .x_offset         (x_offset),
        .player_bar       (player_bar),
        .player_bar_valid (player_bar_valid)
    );

endmodule

// File: tb/tb_anim_offset_ctrl.sv
// Directed bench for anim_offset_ctrl: offset stepping, wrap, direction/speed lag, divider and reset.
module tb_anim_offset_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b0;
    logic [3:0] speed_sw = 4'd4;
    logic       dir_sw = 1'b0;
    logic       frame_tick;
    logic       started;
    logic [9:0] x_offset;
    logic [3:0] player_bar;
    logic       player_bar_valid;

    int n_vec = 0;
    int n_err = 0;
    int tick_cnt = 0;
    int ticks_before;
    int lat;
    bit saw_low;

    always #5 clk = ~clk;

    anim_offset_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .vsync            (vsync),
        .speed_sw         (speed_sw),
        .dir_sw           (dir_sw),
        .frame_tick       (frame_tick),
        .started          (started),
        .x_offset         (x_offset),
        .player_bar       (player_bar),
        .player_bar_valid (player_bar_valid)
    );

    always @(negedge clk) if (frame_tick) tick_cnt++;

    task automatic check(input string tag, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One vsync pulse of 'hold' cycles, then watch the divider for 16 cycles.
    // lat = clk edges from the x_offset update to valid returning high, -1 if it never dropped/recovered.
    task automatic frame(input int hold);
        ticks_before = tick_cnt;
        vsync = 1'b1;
        repeat (hold) @(negedge clk);
        vsync = 1'b0;
        saw_low = 1'b0;
        lat = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (!player_bar_valid) saw_low = 1'b1;
            else if (saw_low && lat < 0) lat = i - 1;
        end
    endtask

    task automatic step(input string tag, input int exp_off, input int exp_bar);
        frame(1);
        check({tag, "_ticks"}, tick_cnt - ticks_before, 1);
        check({tag, "_off"}, x_offset, exp_off);
        check({tag, "_bar"}, player_bar, exp_bar);
        check({tag, "_valid"}, player_bar_valid, 1);
    endtask

    initial begin
        // 1: reset values, then the start tick
        repeat (3) @(negedge clk);
        check("rst_tick", frame_tick, 0);
        check("rst_started", started, 0);
        check("rst_off", x_offset, 0);
        check("rst_bar", player_bar, 5);
        check("rst_valid", player_bar_valid, 1);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        frame(1);
        check("start_ticks", tick_cnt - ticks_before, 1);
        check("start_started", started, 1);
        check("start_off", x_offset, 0);
        check("start_no_div", saw_low, 0);

        // 2: speed 4 forward
        step("fwd4_a", 4, 5);
        step("fwd4_b", 8, 5);
        step("fwd4_c", 12, 5);

        // 3: preload to 396, wrap, then speed 0 steps by 1
        for (int k = 0; k < 96; k++) frame(1);
        check("pre_off", x_offset, 396);
        check("pre_bar", player_bar, 4);
        speed_sw = 4'd0;
        repeat (3) @(negedge clk);
        step("wrap", 0, 5);
        step("spd0_a", 1, 5);

        // 4: direction/speed change lags one frame
        dir_sw = 1'b1;
        speed_sw = 4'd3;
        repeat (3) @(negedge clk);
        step("lag", 2, 5);
        step("rev3_a", 399, 4);
        check("rev3_a_div_low", saw_low, 1);
        check("rev3_a_lat", (lat >= 1 && lat <= 12), 1);
        step("rev3_b", 396, 4);

        // 5: back to forward, land on 0, then walk to 120 and 200
        dir_sw = 1'b0;
        speed_sw = 4'd7;
        repeat (3) @(negedge clk);
        step("rev3_c", 393, 4);
        speed_sw = 4'd4;
        repeat (3) @(negedge clk);
        step("fwd7", 0, 5);
        for (int k = 0; k < 29; k++) frame(1);
        step("div120", 120, 8);
        check("div120_low", saw_low, 1);
        check("div120_lat", (lat >= 1 && lat <= 12), 1);
        for (int k = 0; k < 19; k++) frame(1);
        step("div200", 200, 0);
        check("div200_low", saw_low, 1);
        check("div200_lat", (lat >= 1 && lat <= 12), 1);

        // 6: reset in the middle of a division
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_off", x_offset, 204);
        check("mid_valid", player_bar_valid, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", player_bar_valid, 1);
        check("mid_rst_bar", player_bar, 5);
        check("mid_rst_off", x_offset, 0);
        check("mid_rst_started", started, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        frame(20);
        check("restart_ticks", tick_cnt - ticks_before, 1);
        check("restart_started", started, 1);
        check("restart_off", x_offset, 0);
        check("restart_no_div", saw_low, 0);
        step("restart_step", 4, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
